// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: compares two W-bit operands for equality and unsigned
// magnitude by walking them MSB-first through one shared external 2-bit
// equality slice (eq2), one slice per clock, and stopping at the first
// slice that differs. Results are registered and flagged by a one-cycle
// done pulse; a new start is accepted only while ready is high.

module cmp_seq_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [1:0]   sl_a,
    output logic [1:0]   sl_b,
    input  logic         sl_eq,
    output logic         ready,
    output logic         done,
    output logic         a_eq_b,
    output logic         a_gt_b
);

    localparam int S  = W / 2;
    localparam int IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    ra;
    logic [W-1:0]    rb;
    logic [IW-1:0]   idx;
    logic            last_slice;

    assign last_slice = (idx == '0);
    assign ready      = (state == IDLE);
    assign done       = (state == DONE);

    // State register; reset drops straight back to IDLE, aborting any compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register
            // samples pre-edge values, independent of statement order.
            state <= state_nxt;
        end
    end

    // Next-state logic: leave COMP on the first mismatch or after the LSB slice.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COMP;
            COMP:    if (!sl_eq || last_slice) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slice mux towards eq2: current slice of the captured operands, zero outside COMP.
    always_comb begin
        sl_a = 2'b00;
        sl_b = 2'b00;
        if (state == COMP) begin
            for (int i = 0; i < S; i++) begin
                if (idx == IW'(i)) begin
                    sl_a = ra[2*i +: 2];
                    sl_b = rb[2*i +: 2];
                end
            end
        end
    end

    // Operand capture, slice walk and result registers; results persist across starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand/index registers are reset too, so sl_a/sl_b and the
            // results are fully defined straight out of reset.
            ra     <= '0;
            rb     <= '0;
            idx    <= '0;
            a_eq_b <= 1'b0;
            a_gt_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        idx <= IW'(S - 1);
                    end
                end
                COMP: begin
                    if (!sl_eq) begin
                        a_eq_b <= 1'b0;
                        a_gt_b <= (sl_a > sl_b);
                    end else if (last_slice) begin
                        a_eq_b <= 1'b1;
                        a_gt_b <= 1'b0;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed bench for cmp_seq_ctrl: a W=8 instance for the functional cases
// and a W=2 instance for the exhaustive max-rate sweep. The eq2 slice is
// modelled as a plain 2-bit equality on each instance's slice outputs.

module tb_cmp_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [1:0] sl_a8, sl_b8;
    logic       sl_eq8;
    logic       ready8, done8, eq8, gt8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic [1:0] sl_a2, sl_b2;
    logic       sl_eq2;
    logic       ready2, done2, eq2, gt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign sl_eq8 = (sl_a8 == sl_b8);
    assign sl_eq2 = (sl_a2 == sl_b2);

    cmp_seq_ctrl #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .sl_a(sl_a8), .sl_b(sl_b8), .sl_eq(sl_eq8),
        .ready(ready8), .done(done8), .a_eq_b(eq8), .a_gt_b(gt8)
    );

    cmp_seq_ctrl #(.W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .sl_a(sl_a2), .sl_b(sl_b2), .sl_eq(sl_eq2),
        .ready(ready2), .done(done2), .a_eq_b(eq2), .a_gt_b(gt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one W=8 compare; checks latency, first slice, busy ready and results.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input int k, input logic exp_eq, input logic exp_gt,
                        input logic [1:0] exp_sa, input logic [1:0] exp_sb);
        int cyc;
        logic [1:0] first_sa, first_sb;
        logic busy_ok;
        @(negedge clk);
        check({tag, "_ready_before"}, ready8, 1'b1);
        start8 = 1'b1; a8 = av; b8 = bv;
        @(posedge clk);
        #1 start8 = 1'b0; a8 = ~av; b8 = ~bv;
        cyc = 0;
        busy_ok = 1'b1;
        first_sa = 2'bxx; first_sb = 2'bxx;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin first_sa = sl_a8; first_sb = sl_b8; end
            if (ready8) busy_ok = 1'b0;
            if (done8) break;
        end
        check({tag, "_latency"}, cyc, k + 1);
        check({tag, "_ready_busy"}, busy_ok, 1'b1);
        check({tag, "_first_sl_a"}, first_sa, exp_sa);
        check({tag, "_first_sl_b"}, first_sb, exp_sb);
        check({tag, "_eq"}, eq8, exp_eq);
        check({tag, "_gt"}, gt8, exp_gt);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done8, 1'b0);
        check({tag, "_ready_after"}, ready8, 1'b1);
        check({tag, "_sl_idle"}, {sl_a8, sl_b8}, 4'h0);
    endtask

    initial begin
        int cyc;
        int n_done;
        logic busy_ok;

        // Reset state
        #12;
        check("rst_ready", ready8, 1'b1);
        check("rst_done", done8, 1'b0);
        check("rst_eq", eq8, 1'b0);
        check("rst_gt", gt8, 1'b0);
        check("rst_sl", {sl_a8, sl_b8}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal, MSB mismatch (A>B), LSB mismatch (A<B)
        run8("eq_a5",  8'hA5, 8'hA5, 4, 1'b1, 1'b0, 2'b10, 2'b10);
        run8("msb_c0", 8'hC0, 8'h40, 1, 1'b0, 1'b1, 2'b11, 2'b01);
        run8("lsb_3c", 8'h3C, 8'h3E, 4, 1'b0, 1'b0, 2'b00, 2'b00);

        // Results hold over 10 idle cycles
        busy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (eq8 !== 1'b0 || gt8 !== 1'b0 || done8 !== 1'b0) busy_ok = 1'b0;
        end
        check("hold_idle", busy_ok, 1'b1);

        // Start while busy is ignored; old results not cleared by start
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h12;
        @(posedge clk);
        #1 start8 = 1'b0;
        cyc = 0; n_done = 0; busy_ok = 1'b1;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_result_kept", eq8, 1'b0);
            if (cyc == 2) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
            if (cyc <= 5 && ready8) busy_ok = 1'b0;
            if (done8) begin
                n_done++;
                if (n_done == 1) begin
                    check("busy_latency", cyc, 5);
                    check("busy_eq", eq8, 1'b1);
                    check("busy_gt", gt8, 1'b0);
                end
                start8 = 1'b0;
            end
        end
        check("busy_single_done", n_done, 1);
        check("busy_ready_low", busy_ok, 1'b1);
        check("busy_final_eq", eq8, 1'b1);

        // Reset mid-operation
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h55;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready8, 1'b1);
        check("midrst_done", done8, 1'b0);
        check("midrst_eq", eq8, 1'b0);
        check("midrst_gt", gt8, 1'b0);
        check("midrst_sl", {sl_a8, sl_b8}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        run8("post_rst", 8'h01, 8'h00, 4, 1'b0, 1'b1, 2'b00, 2'b00);

        // W=2 exhaustive sweep at max start rate
        for (int p = 0; p < 16; p++) begin
            logic [1:0] av, bv;
            av = 2'(p >> 2);
            bv = 2'(p);
            @(negedge clk);
            check("w2_ready", ready2, 1'b1);
            start2 = 1'b1; a2 = av; b2 = bv;
            @(posedge clk);
            #1 start2 = 1'b0;
            @(negedge clk);
            check("w2_done_early", done2, 1'b0);
            @(negedge clk);
            check("w2_done", done2, 1'b1);
            check("w2_eq", eq2, (av == bv));
            check("w2_gt", gt2, (av > bv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
# cmp_seq_ctrl

Sequencing controller that compares two W-bit operands by time-sharing a single external 2-bit equality slice (eq2). It walks the operands from the MSB slice down, one slice per clock, and stops early at the first mismatching slice. It reports equality and magnitude (a > b) with a start/done handshake. It sits between the greater-than datapath users and the shared eq2 instance, so that one 2-bit comparator serves any operand width.

## Interface

Parameters:
- W, 8, operand width in bits; must be even and ≥ 2; number of slices S = W/2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request a comparison; sampled only when ready = 1.
- a  in  W  operand A; captured on an accepted start.
- b  in  W  operand B; captured on an accepted start.
- sl_a  out  2  slice of captured A driven to eq2 input j0.
- sl_b  out  2  slice of captured B driven to eq2 input j1.
- sl_eq  in  1  eq2 output aEqb for the current slice; combinational.
- ready  out  1  controller idle, start will be accepted.
- done  out  1  one-cycle pulse, results valid.
- a_eq_b  out  1  registered result: A == B.
- a_gt_b  out  1  registered result: A > B (unsigned).

## Operation

- State machine with three states: IDLE, COMP, DONE.
- IDLE:
  - ready = 1.
  - On start = 1: latch a and b into internal registers ra and rb, set slice index idx = S−1, go to COMP.
  - Otherwise stay in IDLE.
- COMP:
  - sl_a = ra[2·idx+1 : 2·idx], sl_b = rb[2·idx+1 : 2·idx].
  - If sl_eq = 0: register a_eq_b = 0 and a_gt_b = (sl_a > sl_b) as unsigned 2-bit values, then go to DONE.
  - Else if idx = 0: register a_eq_b = 1 and a_gt_b = 0, then go to DONE.
  - Else: decrement idx and stay in COMP.
- DONE: done = 1 for exactly one cycle, then go to IDLE unconditionally.
- Results:
  - a_eq_b and a_gt_b hold until they are overwritten by the next completed comparison.
  - They are not cleared on start.
- sl_a and sl_b outside COMP: drive 2'b00.
- Input changes:
  - start while not in IDLE is ignored; no queuing.
  - Changes on a and b after capture have no effect.
- Reset:
  - rst_n low at any time forces IDLE immediately.
  - All outputs are cleared: ready = 1 once in IDLE, done = 0, a_eq_b = 0, a_gt_b = 0, sl_a = sl_b = 0.
  - ra, rb and idx are cleared.
  - A comparison aborted by reset produces no done pulse.

## Timing

- Edge E0 samples start in IDLE. COMP occupies the cycles after E0 … E(k−1), where k is the number of slices examined (1 ≤ k ≤ S).
- The result is registered at edge Ek. done and the valid results are visible in the cycle after Ek.
- Latency from the start edge to done high is k+1 cycles. For equal operands k = S (W = 8: done in the 5th cycle after E0).
- Return to IDLE at E(k+1), where ready rises. The next start can be accepted at E(k+2).
- The minimum period between accepted starts is therefore k+2 cycles.
- ready is 0 throughout COMP and DONE.
- sl_eq is used in the same cycle that sl_a and sl_b are driven. The eq2 path must close timing combinationally within one clock.

## Test plan

- Equal operands, W = 8: a = 8'hA5, b = 8'hA5, start pulse. Required: 4 COMP cycles, done pulse 5 cycles after the start edge, a_eq_b = 1, a_gt_b = 0.
- MSB-slice mismatch: a = 8'hC0, b = 8'h40. Required: k = 1, done 2 cycles after start, a_eq_b = 0, a_gt_b = 1, sl_a/sl_b observed as 2'b11/2'b01.
- LSB-slice mismatch, A less than B: a = 8'h3C, b = 8'h3E. Required: k = 4, done at cycle 5, a_eq_b = 0, a_gt_b = 0. Results then held unchanged for 10 idle cycles.
- Start while busy: a = 8'h12, b = 8'h12 accepted. While in COMP, apply start with a = 8'hFF, b = 8'h00. Required: the second start is ignored, a single done pulse occurs, a_eq_b = 1, and ready stays 0 until after done.
- Reset mid-operation: a = 8'h55, b = 8'h55, rst_n driven low 2 cycles after start. Required: immediate IDLE, ready = 1, no done pulse, a_eq_b = a_gt_b = 0. A subsequent comparison with a = 8'h01, b = 8'h00 gives a_gt_b = 1.
- Parameter corner, W = 2: exhaustive sweep of all 16 (a, b) pairs back-to-back at the maximum start rate. Required: done always 2 cycles after start, and results match a == b and a > b for every pair.
